// File: rtl/mem_wb_if.sv
// mem_wb_if: EX/MEM request bus into the memory stage and MEM/WB write-back bus out of it.
interface mem_wb_if;
   logic        mem_valid;
   logic        wb_en_in;
   logic        mem_r_en;
   logic        mem_w_en;
   logic [31:0] alu_result;
   logic [31:0] val_rm;
   logic [3:0]  dest_in;
   logic        freeze;
   logic        wb_en;
   logic [3:0]  wb_dest;
   logic [31:0] wb_result;
   modport master (
      output mem_valid, wb_en_in, mem_r_en, mem_w_en, alu_result, val_rm, dest_in,
      input  freeze, wb_en, wb_dest, wb_result
   );
   modport slave (
      input  mem_valid, wb_en_in, mem_r_en, mem_w_en, alu_result, val_rm, dest_in,
      output freeze, wb_en, wb_dest, wb_result
   );
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: multi-cycle data-memory stage with MEM/WB register; stalls upstream while a load/store is in flight.
module mem_wb_stage #(
   parameter int MEM_WAIT  = 3,
   parameter int MEM_WORDS = 64
) (
   input logic     clk,
   input logic     rst,
   mem_wb_if.slave bus
);
   localparam int AW = $clog2(MEM_WORDS);
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   state_t      r_state, w_next;
   logic [3:0]  r_cnt, w_cnt_next;
   logic [31:0] r_addr, r_data;
   logic [3:0]  r_dest;
   logic        r_wb_en_in, r_rd, r_wr;
   logic [31:0] r_mem [MEM_WORDS];
   logic        r_wb_en;
   logic [3:0]  r_wb_dest;
   logic [31:0] r_wb_result;
   logic        w_req, w_freeze, w_load;
   logic [AW-1:0] w_idx;
   assign w_req  = bus.mem_valid & (bus.mem_r_en | bus.mem_w_en);
   assign w_idx  = r_addr[AW+1:2];
   assign w_load = r_rd & ~r_wr;
   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      w_freeze   = 1'b0;
      case (r_state)
         IDLE: begin
            w_freeze = w_req;
            if (w_req) begin
               w_next     = ACCESS;
               w_cnt_next = 4'(MEM_WAIT - 1);
            end
         end
         ACCESS: begin
            w_freeze   = 1'b1;
            w_next     = (r_cnt == 4'd0) ? DONE : ACCESS;
            w_cnt_next = (r_cnt == 4'd0) ? 4'd0 : r_cnt - 4'd1;
         end
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_cnt      <= 4'd0;
         r_addr     <= '0;
         r_data     <= '0;
         r_dest     <= '0;
         r_wb_en_in <= 1'b0;
         r_rd       <= 1'b0;
         r_wr       <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
         if (r_state == IDLE && w_req) begin
            r_addr     <= bus.alu_result;
            r_data     <= bus.val_rm;
            r_dest     <= bus.dest_in;
            r_wb_en_in <= bus.wb_en_in;
            r_rd       <= bus.mem_r_en;
            r_wr       <= bus.mem_w_en;
         end
      end
   end
   // Array is deliberately outside the reset domain so contents survive reset.
   always_ff @(posedge clk)
      if (rst && r_state == DONE && r_wr) r_mem[w_idx] <= r_data;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wb_en     <= 1'b0;
         r_wb_dest   <= 4'd0;
         r_wb_result <= 32'd0;
      end else if (!w_freeze) begin
         r_wb_en     <= (r_state == DONE) ? (r_wb_en_in & w_load) : (bus.mem_valid & bus.wb_en_in);
         r_wb_dest   <= (r_state == DONE) ? r_dest : bus.dest_in;
         r_wb_result <= (r_state == DONE) ? (w_load ? r_mem[w_idx] : r_addr) : bus.alu_result;
      end
   end
   assign bus.freeze    = w_freeze;
   assign bus.wb_en     = r_wb_en;
   assign bus.wb_dest   = r_wb_dest;
   assign bus.wb_result = r_wb_result;
endmodule
